// File: rtl/inout_sram_pkg.sv
// Shared types and default widths for the InOut SRAM access controller.
// Clear-engine state encoding and the upstream request bundle.
package inout_sram_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; push visible at head on the next cycle.
// No internal backpressure: the producer must respect count (push is dropped when full without pop).
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_rdy,
    output logic                       pop_vld,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_vld = (cnt_q != '0);
    assign do_pop  = pop_vld & pop_rdy;
    // Full-with-pop is legal: the slot being written is the one being vacated.
    assign do_push = push_vld & ((cnt_q != CW'(DEPTH)) | do_pop);
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/inout_sram_ctrl.sv
// Request stream to SRAM pins (same-edge), reads return 2 cycles after accept via a credit-gated FIFO; plus zero-fill engine.
// Optional INOUT_SRAM_STATS_EN adds saturating accepted read/write counters.
module inout_sram_ctrl
    import inout_sram_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clr_start,
    input  logic [ADDR_W-1:0] clr_base,
    input  logic [ADDR_W:0]   clr_len,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
`ifdef INOUT_SRAM_STATS_EN
    ,
    output logic [31:0]       stat_rd_cnt,
    output logic [31:0]       stat_wr_cnt
`endif
);

    localparam int CW = $clog2(RSP_DEPTH+1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [ADDR_W:0]   clr_rem_q, clr_rem_d;
    logic              rd_pend_q;
    logic [CW-1:0]     fifo_cnt;
    logic              pop, credit_ok, accept, rd_acc;
    req_t              req_s;

    assign req_s = '{we: req_we, addr: req_addr, wdata: req_wdata};

    // Credit counts the read already in the SRAM pipe plus any slot freed this cycle.
    assign pop       = rsp_valid & rsp_ready;
    assign credit_ok = ({1'b0, fifo_cnt} + (CW+1)'(rd_pend_q)) < ((CW+1)'(RSP_DEPTH) + (CW+1)'(pop));
    assign req_ready = ~rst & (state_q == IDLE) & ~clr_start & (req_s.we | credit_ok);
    assign accept    = req_valid & req_ready;
    assign rd_acc    = accept & ~req_s.we;
    assign sram_oe   = rd_pend_q;
    assign clr_busy  = (state_q != IDLE);

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (rd_pend_q),
        .push_dat (sram_do),
        .pop_rdy  (rsp_ready),
        .pop_vld  (rsp_valid),
        .pop_dat  (rsp_rdata),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            clr_addr_q <= '0;
            clr_rem_q  <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_rem_q  <= clr_rem_d;
            rd_pend_q  <= rd_acc;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_rem_d  = clr_rem_q;
        clr_done   = 1'b0;
        sram_cs    = 1'b0;
        sram_web   = 1'b1;
        sram_a     = req_s.addr;
        sram_di    = req_s.wdata;
        case (state_q)
            IDLE: begin
                sram_cs  = accept;
                sram_web = ~(req_s.we & ~rst);
                if (clr_start) begin
                    clr_addr_d = clr_base;
                    clr_rem_d  = clr_len;
                    state_d    = (clr_len == '0) ? DONE : CLEAR;
                end
            end
            CLEAR: begin
                sram_cs    = 1'b1;
                sram_web   = 1'b0;
                sram_a     = clr_addr_q;
                sram_di    = '0;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                clr_rem_d  = clr_rem_q - (ADDR_W+1)'(1);
                if (clr_rem_q == (ADDR_W+1)'(1)) state_d = DONE;
            end
            DONE: begin
                clr_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef INOUT_SRAM_STATS_EN
    logic        wr_acc;
    logic [31:0] rd_cnt_q, wr_cnt_q;

    assign wr_acc      = accept & req_s.we;
    assign stat_rd_cnt = rd_cnt_q;
    assign stat_wr_cnt = wr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (rd_acc && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (wr_acc && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: doc/inout_sram_ctrl.md
Name: inout_sram_ctrl

Overview:
Upstream access controller for the 32768x16 InOut SRAM macro (CS/OE/WEB/A/DI/DO pins, 1-cycle registered read).
- Converts a valid/ready request stream from the CNN datapath into SRAM pin activity.
- Returns read data through a backpressurable response FIFO.
- Contains a clear engine that zero-fills an address range.

Parameters:
ADDR_W, 15, SRAM address width (word address)
DATA_W, 16, SRAM data width
RSP_DEPTH, 2, response FIFO entries (>=2)

Ports:
clk  in  1  single clock, also drives SRAM CK
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready at posedge clk
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer ready
rsp_rdata  out  DATA_W  read data, in request order
clr_start  in  1  one-cycle pulse, start zero-fill
clr_base  in  ADDR_W  first clear address
clr_len  in  ADDR_W+1  number of words to clear (0..2^ADDR_W)
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse at clear completion
sram_cs  out  1  to SRAM CS
sram_oe  out  1  to SRAM OE
sram_web  out  1  to SRAM WEB (0=write)
sram_a  out  ADDR_W  to SRAM A
sram_di  out  DATA_W  to SRAM DI
sram_do  in  DATA_W  from SRAM DO

Behaviour:
- Reset (async, rst=1):
  - FSM=IDLE; FIFO empty; rd_pend_q=0.
  - Outputs: rsp_valid=0, clr_busy=0, clr_done=0, req_ready=0, sram_cs=0, sram_oe=0, sram_web=1.
- FSM states: IDLE, CLEAR, DONE.
- SRAM pins are combinational from the accepted operation, so the SRAM samples on the same edge as the handshake.
  - IDLE: sram_cs = req_valid&req_ready; sram_web = ~req_we; sram_a = req_addr; sram_di = req_wdata.
  - CLEAR: sram_cs=1, sram_web=0, sram_a=clr_addr_q, sram_di=0.
  - Otherwise: sram_cs=0, sram_web=1.
- Read path:
  - Accept at edge E0 sets rd_pend_q.
  - sram_oe = rd_pend_q, i.e. high exactly in the cycle after a read accept.
  - sram_do is pushed into the FIFO at E1.
  - rsp_valid is visible after E1: 2-cycle latency from accept to rsp_valid.
- Credit rule:
  - Reads are ready iff FSM=IDLE, clr_start=0, and count + rd_pend_q - pop < RSP_DEPTH, where pop = rsp_valid & rsp_ready.
  - This sustains one read per cycle when rsp_ready=1; the FIFO never overflows.
- Writes are ready iff FSM=IDLE and clr_start=0. Writes produce no response.
- FIFO behaviour:
  - First-word-fall-through; rsp_rdata = head.
  - Simultaneous push and pop when full: legal, count unchanged.
  - Pop when empty: impossible by construction.
- Clear engine:
  - In IDLE, clr_start latches clr_base into clr_addr_q and clr_len into clr_rem_q.
  - clr_len=0 goes to DONE; otherwise goes to CLEAR.
  - CLEAR writes 0 each cycle, clr_addr_q += 1 (wraps mod 2^ADDR_W), clr_rem_q -= 1. Go to DONE when clr_rem_q reaches 1 in the same cycle as the write.
  - DONE lasts one cycle: clr_done=1, then return to IDLE.
  - clr_busy = (FSM != IDLE).
  - clr_start in CLEAR/DONE is ignored.
  - clr_start and req_valid in the same IDLE cycle: clear wins; the request is held (req_ready=0).
  - A read in flight when clear starts completes normally. The FIFO keeps draining during clear.
- Reset mid-operation: in-flight read and FIFO contents are discarded; clear is aborted with no clr_done.

Optional Feature:
INOUT_SRAM_STATS_EN
- Defined: adds outputs stat_rd_cnt[31:0] and stat_wr_cnt[31:0].
  - Counters increment on accepted reads and on accepted writes (clear writes excluded).
  - They saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package inout_sram_pkg:
  - ADDR_W/DATA_W defaults.
  - clr_state_t enum {IDLE, CLEAR, DONE}.
  - Request struct {we, addr, wdata}.
- Sub-module: sync_fifo (parameterised width/depth, FWFT, count output), instantiated for the response path.
- The FSM, credit logic and pin mux stay in the top.

Test Plan:
- Write 0x1234 to addr 5, then read addr 5 → sram_oe high exactly one cycle; rsp_valid 2 cycles after accept, rsp_rdata=0x1234.
- Back-to-back reads addr 0..7 (preloaded with addr*3), rsp_ready=1 → req_ready stays 1; 8 responses in order 0,3,...,21 on consecutive cycles.
- Reads with rsp_ready=0 → req_ready drops after 2 accepts; releasing rsp_ready resumes the stream with no lost or duplicated data.
- clr_start base=0x7FFE len=4 → zeros at 0x7FFE, 0x7FFF, 0x0000, 0x0001; clr_busy for 5 cycles; single clr_done pulse.
- clr_start with len=0 in the same cycle as a pending req_valid → no SRAM write, clr_done next cycle, request accepted after DONE.
- Assert rst during CLEAR with 2 responses queued → rsp_valid=0 and clr_busy=0 immediately; no clr_done; fresh read works after release.
